// File: rtl/gpio_bus_slave.sv
// gpio_bus_slave: memory-mapped GPIO responder on the CPU data bus.
// Holds OUT/DIR/RISE_EN/FALL_EN registers, samples pins through a two-flop
// synchronizer and latches enabled edges into a W1C status register that
// drives a level interrupt. Read data is zero when not selected.
// Optional feature macro: GPIO_DEBOUNCE_EN adds a shared debounce counter
// between the synchronizer and the filtered pin value.
module gpio_bus_slave #(
  parameter int unsigned WIDTH           = 32,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             re,
  input  logic [3:0]       we,
  input  logic [2:0]       addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [WIDTH-1:0] stat_q, stat_d;
  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] filt_q, filt_d;
  logic [WIDTH-1:0] rise, fall, clr;
  logic [31:0]      bmask;

  assign bmask = {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};

  // Zero-extend a WIDTH-bit register onto the 32-bit bus.
  function automatic logic [31:0] ext(input logic [WIDTH-1:0] v);
    ext = '0;
    ext[WIDTH-1:0] = v;
  endfunction

  // Byte-lane merge of wdata into a register; bits above WIDTH are dropped.
  function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] old,
                                             input logic [31:0] d,
                                             input logic [31:0] m);
    logic [31:0] r;
    r = (ext(old) & ~m) | (d & m);
    merge = r[WIDTH-1:0];
  endfunction

`ifdef GPIO_DEBOUNCE_EN
  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s2_q;
  logic [CntW-1:0]  cnt_q, cnt_d;

  // One counter shared by all bits: any mismatch run restarts only on agreement.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q + CntW'(1);
    if (s2_q == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      filt_d = s2_q;
      cnt_d  = '0;
    end
  end

  // Second synchronizer stage and debounce counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_q  <= '0;
      cnt_q <= '0;
    end else begin
      s2_q  <= s1_q;
      cnt_q <= cnt_d;
    end
  end
`else
  // Without debounce the filter register is the second synchronizer stage.
  always_comb begin
    filt_d = s1_q;
  end
`endif

  // Edge detect on the filtered value, evaluated at the edge where it changes.
  always_comb begin
    rise = ~filt_q & filt_d;
    fall = filt_q & ~filt_d;
  end

  // Register write decode and status update; set beats a same-cycle clear.
  always_comb begin
    out_d     = out_q;
    dir_d     = dir_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    clr       = '0;
    if (ce) begin
      case (addr)
        3'd0:    out_d     = merge(out_q, wdata, bmask);
        3'd1:    dir_d     = merge(dir_q, wdata, bmask);
        3'd3:    rise_en_d = merge(rise_en_q, wdata, bmask);
        3'd4:    fall_en_d = merge(fall_en_q, wdata, bmask);
        3'd5:    clr       = merge('0, wdata, bmask);
        default: ;
      endcase
    end
    stat_d = (stat_q & ~clr) | (rise & rise_en_q) | (fall & fall_en_q);
  end

  // Architectural registers, first synchronizer stage and filter output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q     <= '0;
      dir_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      stat_q    <= '0;
      s1_q      <= '0;
      filt_q    <= '0;
    end else begin
      out_q     <= out_d;
      dir_q     <= dir_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      stat_q    <= stat_d;
      s1_q      <= gpio_in;
      filt_q    <= filt_d;
    end
  end

  // Combinational read mux; zero when not selected so the top can OR buses.
  always_comb begin
    rdata = '0;
    if (ce && re) begin
      case (addr)
        3'd0:    rdata = ext(out_q);
        3'd1:    rdata = ext(dir_q);
        3'd2:    rdata = ext(filt_q);
        3'd3:    rdata = ext(rise_en_q);
        3'd4:    rdata = ext(fall_en_q);
        3'd5:    rdata = ext(stat_q);
        default: rdata = '0;
      endcase
    end
  end

  assign gpio_out = out_q;
  assign gpio_oe  = dir_q;
  assign irq      = |stat_q;

endmodule
